bbox_painter: RTL and testbench

- Writer side of the 36x3 image RAM: paints a rectangle (outline or filled) of a given colour into the 6x6, 3-bit-per-pixel frame buffer.
- The edge-finding readers scan that buffer for shapes.
- Used to load test shapes before a search, and to overlay the found bounding box (top/bottom/left/right) after one.
- Issues one RAM write per cycle through a start/busy/done handshake.

---
 rtl/bbox_painter_pkg.sv | 68 ++++++
 rtl/bbox_painter_address_translator.sv | 12 +
 rtl/bbox_painter.sv | 185 ++++++++++++++++++
 tb/tb_bbox_painter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bbox_painter_pkg.sv
// Shared constants, state encoding and per-pixel paint rule for the 6x6 frame-buffer writer.
package bbox_painter_pkg;

    localparam int XSZ     = 3;
    localparam int YSZ     = 3;
    localparam int ADDR_SZ = 6;
    localparam int COL_SZ  = 3;
    localparam int WIDTH   = 6;
    localparam int HEIGHT  = 6;

    localparam logic [COL_SZ-1:0] BG_COLOUR   = 3'd7;
    localparam logic [COL_SZ-1:0] EDGE_COLOUR = 3'd0;

    localparam logic [XSZ-1:0] X_MAX = XSZ'(WIDTH - 1);
    localparam logic [YSZ-1:0] Y_MAX = YSZ'(HEIGHT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic              en;
        logic [COL_SZ-1:0] data;
    } pixel_t;

    function automatic logic isValidBox(
        input logic [YSZ-1:0] top,
        input logic [YSZ-1:0] bottom,
        input logic [XSZ-1:0] left,
        input logic [XSZ-1:0] right
    );
        return (top <= bottom) && (left <= right) && (bottom <= Y_MAX) && (right <= X_MAX);
    endfunction

    // Box pixels (border always, interior only when filled) take the box colour;
    // everything else is background on a clearing pass and skipped otherwise.
    function automatic pixel_t paintPixel(
        input logic [XSZ-1:0]    x,
        input logic [YSZ-1:0]    y,
        input logic [YSZ-1:0]    top,
        input logic [YSZ-1:0]    bottom,
        input logic [XSZ-1:0]    left,
        input logic [XSZ-1:0]    right,
        input logic [COL_SZ-1:0] colour,
        input logic              fill,
        input logic              clearBg
    );
        logic   inBox;
        logic   border;
        pixel_t p;
        inBox  = (y >= top) && (y <= bottom) && (x >= left) && (x <= right);
        border = inBox && ((y == top) || (y == bottom) || (x == left) || (x == right));
        if (border || (inBox && fill)) begin
            p.en   = 1'b1;
            p.data = colour;
        end else if (clearBg) begin
            p.en   = 1'b1;
            p.data = BG_COLOUR;
        end else begin
            p.en   = 1'b0;
            p.data = EDGE_COLOUR;
        end
        return p;
    endfunction

endpackage

// File: rtl/bbox_painter_address_translator.sv
// Maps (x,y) to the linear frame-buffer address y*6+x; shared with the edge-finding readers.
module bbox_painter_address_translator
    import bbox_painter_pkg::*;
(
    input  logic [XSZ-1:0]     x,
    input  logic [YSZ-1:0]     y,
    output logic [ADDR_SZ-1:0] addr
);

    assign addr = ADDR_SZ'({y, 2'b00}) + ADDR_SZ'({y, 1'b0}) + ADDR_SZ'(x);

endmodule

// File: rtl/bbox_painter.sv
// Paints an outlined or filled rectangle into the 6x6 frame buffer, one RAM write per cycle,
// behind a start/busy/done handshake.
module bbox_painter
    import bbox_painter_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [YSZ-1:0]     top,
    input  logic [YSZ-1:0]     bottom,
    input  logic [XSZ-1:0]     left,
    input  logic [XSZ-1:0]     right,
    input  logic [COL_SZ-1:0]  colour,
    input  logic               fill,
    input  logic               clear_bg,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [ADDR_SZ-1:0] wr_addr,
    output logic [COL_SZ-1:0]  wr_data,
    output logic               wr_en
);

    state_t state_r, stateNext_s;

    logic [YSZ-1:0]    top_r, bottom_r, y_r;
    logic [XSZ-1:0]    left_r, right_r, x_r;
    logic [COL_SZ-1:0] colour_r;
    logic              fill_r, clearBg_r;

    logic [YSZ-1:0]    boxTop_s, boxBottom_s, yStart_s, yEnd_s, pixY_s;
    logic [XSZ-1:0]    boxLeft_s, boxRight_s, xStart_s, xEnd_s, pixX_s;
    logic [COL_SZ-1:0] boxColour_s;
    logic              boxFill_s, boxClear_s;
    logic              lastCol_s, lastPix_s;
    logic              latch_s, emit_s;
    logic              busyNext_s, doneNext_s, errNext_s, wrEnNext_s;
    logic [COL_SZ-1:0] wrDataNext_s;
    logic [ADDR_SZ-1:0] pixAddr_s, wrAddrNext_s;
    pixel_t            pixel_s;

    // Raw inputs describe the box on the accepting edge; latched copies afterwards.
    always_comb begin
        if (state_r == ST_IDLE) begin
            boxTop_s    = top;
            boxBottom_s = bottom;
            boxLeft_s   = left;
            boxRight_s  = right;
            boxColour_s = colour;
            boxFill_s   = fill;
            boxClear_s  = clear_bg;
        end else begin
            boxTop_s    = top_r;
            boxBottom_s = bottom_r;
            boxLeft_s   = left_r;
            boxRight_s  = right_r;
            boxColour_s = colour_r;
            boxFill_s   = fill_r;
            boxClear_s  = clearBg_r;
        end
        xStart_s  = boxClear_s ? 3'd0  : boxLeft_s;
        xEnd_s    = boxClear_s ? X_MAX : boxRight_s;
        yStart_s  = boxClear_s ? 3'd0  : boxTop_s;
        yEnd_s    = boxClear_s ? Y_MAX : boxBottom_s;
        lastCol_s = (x_r == xEnd_s);
        lastPix_s = lastCol_s && (y_r == yEnd_s);
    end

    // Next state and the pixel position whose write goes out in the following cycle.
    always_comb begin
        stateNext_s = state_r;
        busyNext_s  = 1'b0;
        doneNext_s  = 1'b0;
        errNext_s   = 1'b0;
        latch_s     = 1'b0;
        emit_s      = 1'b0;
        pixX_s      = x_r;
        pixY_s      = y_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    latch_s    = 1'b1;
                    busyNext_s = 1'b1;
                    if (!isValidBox(boxTop_s, boxBottom_s, boxLeft_s, boxRight_s)) begin
                        stateNext_s = ST_DONE;
                        doneNext_s  = 1'b1;
                        errNext_s   = 1'b1;
                    end else begin
                        stateNext_s = ST_SCAN;
                        emit_s      = 1'b1;
                        pixX_s      = xStart_s;
                        pixY_s      = yStart_s;
                    end
                end else begin
                    stateNext_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                busyNext_s = 1'b1;
                if (lastPix_s) begin
                    stateNext_s = ST_DONE;
                    doneNext_s  = 1'b1;
                end else if (lastCol_s) begin
                    emit_s = 1'b1;
                    pixX_s = xStart_s;
                    pixY_s = y_r + 3'd1;
                end else begin
                    emit_s = 1'b1;
                    pixX_s = x_r + 3'd1;
                end
            end
            ST_DONE: begin
                stateNext_s = ST_IDLE;
            end
            default: begin
                stateNext_s = ST_IDLE;
            end
        endcase
    end

    bbox_painter_address_translator uAddr (
        .x    (pixX_s),
        .y    (pixY_s),
        .addr (pixAddr_s)
    );

    // Write decision for the upcoming pixel.
    always_comb begin
        pixel_s = paintPixel(pixX_s, pixY_s, boxTop_s, boxBottom_s, boxLeft_s, boxRight_s,
                             boxColour_s, boxFill_s, boxClear_s);
        if (emit_s) begin
            wrEnNext_s   = pixel_s.en;
            wrDataNext_s = pixel_s.data;
            wrAddrNext_s = pixAddr_s;
        end else begin
            wrEnNext_s   = 1'b0;
            wrDataNext_s = EDGE_COLOUR;
            wrAddrNext_s = 6'd0;
        end
    end

    // State, request latches, raster counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            top_r     <= 3'd0;
            bottom_r  <= 3'd0;
            left_r    <= 3'd0;
            right_r   <= 3'd0;
            colour_r  <= 3'd0;
            fill_r    <= 1'b0;
            clearBg_r <= 1'b0;
            x_r       <= 3'd0;
            y_r       <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= 6'd0;
            wr_data   <= 3'd0;
        end else begin
            state_r <= stateNext_s;
            if (latch_s) begin
                top_r     <= top;
                bottom_r  <= bottom;
                left_r    <= left;
                right_r   <= right;
                colour_r  <= colour;
                fill_r    <= fill;
                clearBg_r <= clear_bg;
            end
            if (emit_s) begin
                x_r <= pixX_s;
                y_r <= pixY_s;
            end
            busy    <= busyNext_s;
            done    <= doneNext_s;
            err     <= errNext_s;
            wr_en   <= wrEnNext_s;
            wr_addr <= wrAddrNext_s;
            wr_data <= wrDataNext_s;
        end
    end

endmodule

// File: tb/tb_bbox_painter.sv
// Self-checking bench for bbox_painter: queue-based behavioural model, per-cycle compare,
// directed cases with literal expectations, then randomized traffic.
module tb_bbox_painter;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [2:0] top = 3'd0, bottom = 3'd0, left = 3'd0, right = 3'd0, colour = 3'd0;
    logic       fill = 1'b0, clear_bg = 1'b0;
    logic       busy, done, err, wr_en;
    logic [5:0] wr_addr;
    logic [2:0] wr_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bbox_painter dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .top      (top),
        .bottom   (bottom),
        .left     (left),
        .right    (right),
        .colour   (colour),
        .fill     (fill),
        .clear_bg (clear_bg),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_en    (wr_en)
    );

    typedef struct {
        bit busy;
        bit done;
        bit err;
        bit en;
        int addr;
        int data;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   started = 1'b0;

    int ram[36];
    bit written[36];
    int wrCount = 0, doneCyc = 0, cyc = 0, errCount = 0;
    bit prevBusy = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(bit b, bit d, bit e, bit en, int a, int dt);
        exp_t r;
        r.busy = b; r.done = d; r.err = e; r.en = en; r.addr = a; r.data = dt;
        return r;
    endfunction

    // Expected output stream for one accepted request, one entry per cycle after acceptance.
    task automatic build(input int t, input int b, input int l, input int r,
                         input int col, input bit f, input bit clr);
        int xs, xe, ys, ye;
        bit inb, brd;
        if (t > b || l > r || b >= 6 || r >= 6) begin
            q.push_back(mk(1, 1, 1, 0, 0, 0));
        end else begin
            xs = clr ? 0 : l;  xe = clr ? 5 : r;
            ys = clr ? 0 : t;  ye = clr ? 5 : b;
            for (int y = ys; y <= ye; y++) begin
                for (int x = xs; x <= xe; x++) begin
                    inb = (y >= t) && (y <= b) && (x >= l) && (x <= r);
                    brd = inb && (y == t || y == b || x == l || x == r);
                    if (brd || (inb && f))  q.push_back(mk(1, 0, 0, 1, y * 6 + x, col));
                    else if (clr)           q.push_back(mk(1, 0, 0, 1, y * 6 + x, 7));
                    else                    q.push_back(mk(1, 0, 0, 0, 0, 0));
                end
            end
            q.push_back(mk(1, 1, 0, 0, 0, 0));
        end
        q.push_back(mk(0, 0, 0, 0, 0, 0));
    endtask

    // Model: advances on every rising edge exactly as the request protocol dictates.
    initial begin
        cur = mk(0, 0, 0, 0, 0, 0);
        forever begin
            @(posedge clk);
            started = 1'b1;
            if (!resetn) begin
                q.delete();
                cur = mk(0, 0, 0, 0, 0, 0);
            end else begin
                if (q.size() == 0 && start)
                    build(top, bottom, left, right, colour, fill, clear_bg);
                if (q.size() > 0) cur = q.pop_front();
                else              cur = mk(0, 0, 0, 0, 0, 0);
            end
        end
    end

    // Compare DUT against the model on every falling edge and keep a shadow RAM plus stats.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check("busy", busy, cur.busy);
                check("done", done, cur.done);
                check("err", err, cur.err);
                check("wr_en", wr_en, cur.en);
                if (cur.en) begin
                    check("wr_addr", wr_addr, cur.addr);
                    check("wr_data", wr_data, cur.data);
                end
                if (busy && !prevBusy) begin
                    cyc = 0; wrCount = 0; doneCyc = 0; errCount = 0;
                end
                if (busy) cyc++;
                if (wr_en) begin
                    wrCount++;
                    if (wr_addr < 6'd36) begin
                        ram[wr_addr]     = int'(wr_data);
                        written[wr_addr] = 1'b1;
                    end
                end
                if (done) begin
                    doneCyc = cyc;
                    if (err) errCount++;
                end
                prevBusy = busy;
            end
        end
    end

    task automatic clearShadow();
        for (int i = 0; i < 36; i++) begin
            written[i] = 1'b0;
            ram[i]     = -1;
        end
    endtask

    task automatic go(input int t, input int b, input int l, input int r,
                      input int col, input bit f, input bit clr);
        @(negedge clk);
        top = 3'(t); bottom = 3'(b); left = 3'(l); right = 3'(r);
        colour = 3'(col); fill = f; clear_bg = clr; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        check("idle_timeout", q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        clearShadow();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        resetn = 1'b1;
        @(negedge clk);

        // Outline: rows 2..4, columns 1..3, only interior (x=2,y=3) skipped.
        clearShadow();
        go(2, 4, 1, 3, 0, 1'b0, 1'b0);
        waitIdle();
        check("outline_writes", wrCount, 8);
        check("outline_done_cycle", doneCyc, 10);
        check("outline_err", errCount, 0);
        check("outline_addr20_skipped", written[20], 0);
        check("outline_addr19", ram[19], 0);
        check("outline_addr26", ram[26], 0);

        // Full-frame filled box.
        clearShadow();
        go(0, 5, 0, 5, 3, 1'b1, 1'b1);
        waitIdle();
        check("full_writes", wrCount, 36);
        check("full_done_cycle", doneCyc, 37);
        cnt = 0;
        for (int i = 0; i < 36; i++) if (ram[i] == 3) cnt++;
        check("full_all_colour3", cnt, 36);

        // 1x1 box on a cleared frame.
        clearShadow();
        go(5, 5, 5, 5, 0, 1'b0, 1'b1);
        waitIdle();
        check("dot_writes", wrCount, 36);
        check("dot_addr35", ram[35], 0);
        check("dot_addr0", ram[0], 7);
        check("dot_addr34", ram[34], 7);

        // Rejected requests.
        go(4, 2, 0, 1, 1, 1'b0, 1'b0);
        waitIdle();
        check("inv1_done_cycle", doneCyc, 1);
        check("inv1_err", errCount, 1);
        check("inv1_writes", wrCount, 0);
        go(0, 6, 0, 1, 1, 1'b0, 1'b0);
        waitIdle();
        check("inv2_done_cycle", doneCyc, 1);
        check("inv2_err", errCount, 1);
        check("inv2_writes", wrCount, 0);

        // start re-pulsed mid-scan with another box must be ignored.
        clearShadow();
        go(0, 1, 0, 5, 5, 1'b0, 1'b0);
        top = 3'd5; bottom = 3'd5; left = 3'd0; right = 3'd5; colour = 3'd2; clear_bg = 1'b1;
        start = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
        waitIdle();
        check("repulse_writes", wrCount, 12);
        check("repulse_done_cycle", doneCyc, 13);
        check("repulse_addr30", written[30], 0);
        check("repulse_addr11", ram[11], 5);

        // Reset during the 5th scan cycle.
        clearShadow();
        go(0, 5, 0, 5, 2, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_wr_en", wr_en, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_writes", wrCount, 5);
        check("midrst_no_done", doneCyc, 0);
        go(2, 4, 1, 3, 4, 1'b0, 1'b0);
        waitIdle();
        check("after_rst_writes", wrCount, 8);
        check("after_rst_done_cycle", doneCyc, 10);

        // Randomized traffic: inputs change every cycle, occasional resets.
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                top = 3'($urandom_range(0, 7));
                bottom = 3'($urandom_range(0, 7));
            end else begin
                top = 3'($urandom_range(0, 5));
                bottom = 3'($urandom_range(int'(top), 5));
            end
            if ($urandom_range(0, 7) == 0) begin
                left = 3'($urandom_range(0, 7));
                right = 3'($urandom_range(0, 7));
            end else begin
                left = 3'($urandom_range(0, 5));
                right = 3'($urandom_range(int'(left), 5));
            end
            colour   = 3'($urandom_range(0, 7));
            fill     = 1'($urandom_range(0, 1));
            clear_bg = ($urandom_range(0, 3) == 0);
            start    = ($urandom_range(0, 3) == 0);
            resetn   = ($urandom_range(0, 299) != 0);
        end
        start = 1'b0;
        resetn = 1'b1;
        waitIdle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
